// File: rtl/crossbar_scheduler_if.sv
// Batch-in / bank-write-out bundle for the crossbar scheduler.
// The master drives batches and receives bank writes; the slave is the scheduler.
interface crossbar_scheduler_if #(
  parameter int unsigned BANK_COUNT  = 16,
  parameter int unsigned ENTRY_COUNT = 16,
  parameter int unsigned COORD_WIDTH = 8
);

  // Batch side
  logic                   in_valid;
  logic                   in_ready;
  logic [1:0]             in_bitwidth;
  logic [ENTRY_COUNT-1:0] in_entry_valid;
  logic [COORD_WIDTH-1:0] in_row  [ENTRY_COUNT];
  logic [COORD_WIDTH-1:0] in_col  [ENTRY_COUNT];
  logic [7:0]             in_data [ENTRY_COUNT];

  // Accumulator bank write side
  logic [BANK_COUNT-1:0]  buf_we;
  logic [COORD_WIDTH-1:0] buf_row  [BANK_COUNT];
  logic [COORD_WIDTH-1:0] buf_col  [BANK_COUNT];
  logic [7:0]             buf_data [BANK_COUNT];

  // Status
  logic                   crossbar_stall;
  logic                   batch_done;
  logic [15:0]            conflict_cycles;

  modport master (
    output in_valid, in_bitwidth, in_entry_valid, in_row, in_col, in_data,
    input  in_ready, buf_we, buf_row, buf_col, buf_data,
    input  crossbar_stall, batch_done, conflict_cycles
  );

  modport slave (
    input  in_valid, in_bitwidth, in_entry_valid, in_row, in_col, in_data,
    output in_ready, buf_we, buf_row, buf_col, buf_data,
    output crossbar_stall, batch_done, conflict_cycles
  );

endinterface

// File: rtl/crossbar_scheduler.sv
// Crossbar scheduler: accepts a batch of product entries and drains them into
// accumulator banks, granting at most one entry per bank per cycle, lowest index first.
module crossbar_scheduler #(
  parameter int unsigned BANK_COUNT  = 16,
  parameter int unsigned ENTRY_COUNT = 16,
  parameter int unsigned COORD_WIDTH = 8
) (
  input logic                 clk,
  input logic                 reset_n,
  crossbar_scheduler_if.slave bus
);

  localparam int unsigned BankW = $clog2(BANK_COUNT);
  // Wide enough for col + 3*row + 3*BANK_COUNT without overflow.
  localparam int unsigned SumW  = COORD_WIDTH + 11;

  typedef enum logic [0:0] {StIdle, StIssue} state_e;

  state_e                 state_q, state_d;
  logic [ENTRY_COUNT-1:0] pending_q, pending_d;
  logic [ENTRY_COUNT-1:0] grant;
  logic [BANK_COUNT-1:0]  claimed;

  // Latched batch
  logic [1:0]             bw_q;
  logic [COORD_WIDTH-1:0] row_q  [ENTRY_COUNT];
  logic [COORD_WIDTH-1:0] col_q  [ENTRY_COUNT];
  logic [7:0]             data_q [ENTRY_COUNT];
  logic [BankW-1:0]       bank   [ENTRY_COUNT];

  // Bank write registers and their next values
  logic [BANK_COUNT-1:0]  we_d, we_q;
  logic [COORD_WIDTH-1:0] wr_row_d  [BANK_COUNT];
  logic [COORD_WIDTH-1:0] wr_row_q  [BANK_COUNT];
  logic [COORD_WIDTH-1:0] wr_col_d  [BANK_COUNT];
  logic [COORD_WIDTH-1:0] wr_col_q  [BANK_COUNT];
  logic [7:0]             wr_data_d [BANK_COUNT];
  logic [7:0]             wr_data_q [BANK_COUNT];

  logic                   done_d, done_q;
  logic [15:0]            conf_d, conf_q;
  logic                   accept;

  assign accept = (state_q == StIdle) && bus.in_valid;

  // Map each latched entry to its bank; the final cast is the power-of-two modulo.
  always_comb begin
    for (int i = 0; i < ENTRY_COUNT; i++) begin
      bank[i] = BankW'(SumW'(col_q[i])
                + SumW'(3) * (SumW'(row_q[i]) >> bw_q)
                + (SumW'(row_q[i]) & ((SumW'(1) << bw_q) - SumW'(1)))
                  * (SumW'(BANK_COUNT) >> bw_q));
    end
  end

  // Priority grant: ascending index, first pending entry per bank wins this cycle.
  always_comb begin
    claimed = '0;
    grant   = '0;
    we_d    = '0;
    for (int k = 0; k < BANK_COUNT; k++) begin
      wr_row_d[k]  = wr_row_q[k];
      wr_col_d[k]  = wr_col_q[k];
      wr_data_d[k] = wr_data_q[k];
    end
    for (int i = 0; i < ENTRY_COUNT; i++) begin
      if ((state_q == StIssue) && pending_q[i] && !claimed[bank[i]]) begin
        grant[i]           = 1'b1;
        claimed[bank[i]]   = 1'b1;
        we_d[bank[i]]      = 1'b1;
        wr_row_d[bank[i]]  = row_q[i];
        wr_col_d[bank[i]]  = col_q[i];
        wr_data_d[bank[i]] = data_q[i];
      end
    end
  end

  // Next-state, pending mask, completion pulse and conflict counter.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    done_d    = 1'b0;
    conf_d    = conf_q;
    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          state_d   = StIssue;
          pending_d = bus.in_entry_valid;
        end
      end
      StIssue: begin
        pending_d = pending_q & ~grant;
        if (pending_d == '0) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end else if (conf_q != 16'hFFFF) begin
          // Leftover pending entries mean this cycle deferred someone.
          conf_d = conf_q + 16'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Control state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      pending_q <= '0;
      done_q    <= 1'b0;
      conf_q    <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      done_q    <= done_d;
      conf_q    <= conf_d;
    end
  end

  // Capture the batch on acceptance; precision mode 3 behaves as 2.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bw_q <= 2'd0;
      for (int i = 0; i < ENTRY_COUNT; i++) begin
        row_q[i]  <= '0;
        col_q[i]  <= '0;
        data_q[i] <= '0;
      end
    end else if (accept) begin
      bw_q <= (bus.in_bitwidth == 2'd3) ? 2'd2 : bus.in_bitwidth;
      for (int i = 0; i < ENTRY_COUNT; i++) begin
        row_q[i]  <= bus.in_row[i];
        col_q[i]  <= bus.in_col[i];
        data_q[i] <= bus.in_data[i];
      end
    end
  end

  // Bank write registers; ungranted banks hold their last coordinates and data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      we_q <= '0;
      for (int k = 0; k < BANK_COUNT; k++) begin
        wr_row_q[k]  <= '0;
        wr_col_q[k]  <= '0;
        wr_data_q[k] <= '0;
      end
    end else begin
      we_q <= we_d;
      for (int k = 0; k < BANK_COUNT; k++) begin
        wr_row_q[k]  <= wr_row_d[k];
        wr_col_q[k]  <= wr_col_d[k];
        wr_data_q[k] <= wr_data_d[k];
      end
    end
  end

  assign bus.in_ready        = (state_q == StIdle);
  assign bus.crossbar_stall  = (state_q == StIssue);
  assign bus.batch_done      = done_q;
  assign bus.conflict_cycles = conf_q;
  assign bus.buf_we          = we_q;

  for (genvar g = 0; g < BANK_COUNT; g++) begin : g_bank_out
    assign bus.buf_row[g]  = wr_row_q[g];
    assign bus.buf_col[g]  = wr_col_q[g];
    assign bus.buf_data[g] = wr_data_q[g];
  end

endmodule

// File: tb/tb_crossbar_scheduler.sv
// Bench for crossbar_scheduler: directed batches plus random batches, each checked
// cycle by cycle against a behavioural per-bank drain model.
module tb_crossbar_scheduler;

  localparam int BC = 16;
  localparam int EC = 16;
  localparam int CW = 8;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;

  crossbar_scheduler_if #(.BANK_COUNT(BC), .ENTRY_COUNT(EC), .COORD_WIDTH(CW)) bus ();

  crossbar_scheduler #(.BANK_COUNT(BC), .ENTRY_COUNT(EC), .COORD_WIDTH(CW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;

  // Model of the bank registers and the conflict counter
  int m_row  [BC];
  int m_col  [BC];
  int m_data [BC];
  int m_conf;

  // Stimulus for the next batch
  int t_row  [EC];
  int t_col  [EC];
  int t_data [EC];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int bank_of(input int row, input int col, input int b);
    return (col + 3 * (row >> b) + (row % (1 << b)) * (BC >> b)) % BC;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < BC; k++) begin
      m_row[k]  = 0;
      m_col[k]  = 0;
      m_data[k] = 0;
    end
    m_conf = 0;
  endtask

  task automatic check_banks(input string tag);
    for (int k = 0; k < BC; k++) begin
      check($sformatf("%s buf_row[%0d]", tag, k), 32'(bus.buf_row[k]), 32'(m_row[k]));
      check($sformatf("%s buf_col[%0d]", tag, k), 32'(bus.buf_col[k]), 32'(m_col[k]));
      check($sformatf("%s buf_data[%0d]", tag, k), 32'(bus.buf_data[k]), 32'(m_data[k]));
    end
  endtask

  task automatic clear_t();
    for (int i = 0; i < EC; i++) begin
      t_row[i]  = 0;
      t_col[i]  = 0;
      t_data[i] = 0;
    end
  endtask

  // Present a batch at posedge+1 and follow it to completion. abort_cycle > 0 pulls
  // reset in the middle of that issue cycle instead.
  task automatic run_batch(input logic [EC-1:0] mask, input int bw, input int abort_cycle);
    int b;
    int bank [EC];
    logic [EC-1:0] rem;
    logic [EC-1:0] gnt;
    logic [BC-1:0] exp_we;
    bit found;
    int cyc;
    b = (bw == 3) ? 2 : bw;
    bus.in_valid       = 1'b1;
    bus.in_bitwidth    = 2'(bw);
    bus.in_entry_valid = mask;
    for (int i = 0; i < EC; i++) begin
      bus.in_row[i]  = t_row[i][CW-1:0];
      bus.in_col[i]  = t_col[i][CW-1:0];
      bus.in_data[i] = t_data[i][7:0];
      bank[i]        = bank_of(t_row[i], t_col[i], b);
    end
    check("ready_idle", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    // Inputs are don't-care once accepted
    bus.in_valid       = 1'($urandom_range(0, 1));
    bus.in_bitwidth    = 2'($urandom_range(0, 3));
    bus.in_entry_valid = 16'($urandom);
    for (int i = 0; i < EC; i++) begin
      bus.in_row[i]  = 8'($urandom);
      bus.in_col[i]  = 8'($urandom);
      bus.in_data[i] = 8'($urandom);
    end
    rem = mask;
    cyc = 0;
    do begin
      if (cyc + 1 == abort_cycle) begin
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        check("rst ready", 32'(bus.in_ready), 32'd1);
        check("rst stall", 32'(bus.crossbar_stall), 32'd0);
        check("rst done", 32'(bus.batch_done), 32'd0);
        check("rst conf", 32'(bus.conflict_cycles), 32'd0);
        check("rst we", 32'(bus.buf_we), 32'd0);
        check_banks("rst");
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        check("rst hold we", 32'(bus.buf_we), 32'd0);
        check("rst hold done", 32'(bus.batch_done), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
        check("post rst we", 32'(bus.buf_we), 32'd0);
        check("post rst ready", 32'(bus.in_ready), 32'd1);
        check("post rst done", 32'(bus.batch_done), 32'd0);
        return;
      end
      check("stall busy", 32'(bus.crossbar_stall), 32'd1);
      check("ready busy", 32'(bus.in_ready), 32'd0);
      check("done busy", 32'(bus.batch_done), 32'd0);
      // Each bank takes its lowest-indexed still-pending entry
      gnt    = '0;
      exp_we = '0;
      for (int k = 0; k < BC; k++) begin
        found = 1'b0;
        for (int i = 0; i < EC; i++) begin
          if (!found && rem[i] && bank[i] == k) begin
            found     = 1'b1;
            gnt[i]    = 1'b1;
            exp_we[k] = 1'b1;
            m_row[k]  = t_row[i];
            m_col[k]  = t_col[i];
            m_data[k] = t_data[i];
          end
        end
      end
      if ((rem & ~gnt) != '0 && m_conf < 65535) m_conf++;
      rem = rem & ~gnt;
      cyc++;
      @(posedge clk); #1;
      check($sformatf("buf_we c%0d", cyc), 32'(bus.buf_we), 32'(exp_we));
      check_banks($sformatf("c%0d", cyc));
      check($sformatf("done c%0d", cyc), 32'(bus.batch_done), 32'(rem == '0));
      check($sformatf("conf c%0d", cyc), 32'(bus.conflict_cycles), 32'(m_conf));
    end while (rem != '0 && cyc < EC + 2);
    bus.in_valid = 1'b0;
    check("ready after", 32'(bus.in_ready), 32'd1);
    check("stall after", 32'(bus.crossbar_stall), 32'd0);
  endtask

  initial begin
    bus.in_valid       = 1'b0;
    bus.in_bitwidth    = 2'd0;
    bus.in_entry_valid = '0;
    for (int i = 0; i < EC; i++) begin
      bus.in_row[i]  = '0;
      bus.in_col[i]  = '0;
      bus.in_data[i] = '0;
    end
    model_reset();
    clear_t();

    // Reset values, checked before any clock edge
    #1 reset_n = 1'b0;
    #1;
    check("reset ready", 32'(bus.in_ready), 32'd1);
    check("reset stall", 32'(bus.crossbar_stall), 32'd0);
    check("reset done", 32'(bus.batch_done), 32'd0);
    check("reset conf", 32'(bus.conflict_cycles), 32'd0);
    check("reset we", 32'(bus.buf_we), 32'd0);
    check_banks("reset");
    #20 reset_n = 1'b1;
    @(posedge clk); #1;

    // Two entries on distinct banks: one cycle
    clear_t();
    t_col[0] = 5; t_data[0] = 8'h11;
    t_row[1] = 1; t_col[1] = 5; t_data[1] = 8'h22;
    run_batch(16'h0003, 0, 0);
    check("d033 bank5", 32'(bus.buf_data[5]), 32'h11);
    check("d033 bank8", 32'(bus.buf_data[8]), 32'h22);
    check("d033 conf", 32'(bus.conflict_cycles), 32'd0);

    // Same bank twice: two cycles, one conflict
    clear_t();
    t_col[0] = 5; t_data[0] = 8'h11;
    t_col[1] = 5; t_data[1] = 8'h22;
    run_batch(16'h0003, 0, 0);
    check("d034 bank5", 32'(bus.buf_data[5]), 32'h22);
    check("d034 conf", 32'(bus.conflict_cycles), 32'd1);

    // Precision mode 2 mapping
    clear_t();
    t_row[0] = 5; t_col[0] = 2; t_data[0] = 8'h5A;
    run_batch(16'h0001, 2, 0);
    check("d035 row9", 32'(bus.buf_row[9]), 32'd5);
    check("d035 col9", 32'(bus.buf_col[9]), 32'd2);

    // Worst case: every entry on bank 0
    clear_t();
    for (int i = 0; i < EC; i++) t_data[i] = i;
    run_batch(16'hFFFF, 0, 0);
    check("d036 data0", 32'(bus.buf_data[0]), 32'd15);
    check("d036 conf", 32'(bus.conflict_cycles), 32'd16);

    // Reset during the second cycle of a two-cycle batch
    clear_t();
    t_col[0] = 5; t_data[0] = 8'h11;
    t_col[1] = 5; t_data[1] = 8'h22;
    run_batch(16'h0003, 0, 2);

    // Empty mask
    clear_t();
    run_batch(16'h0000, 1, 0);

    // Random batches, alternating tight and wide coordinate ranges
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < EC; i++) begin
        t_row[i]  = (n % 2 == 0) ? $urandom_range(0, 3) : $urandom_range(0, 255);
        t_col[i]  = (n % 2 == 0) ? $urandom_range(0, 3) : $urandom_range(0, 255);
        t_data[i] = $urandom_range(0, 255);
      end
      run_batch(16'($urandom), $urandom_range(0, 3), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/crossbar_scheduler.md
CROSSBAR_SCHEDULER -- requirements
Module: crossbar_scheduler

Interface
REQ-001: Parameter BANK_COUNT, default 16: number of accumulator buffer banks; power of two, 4..256.
REQ-002: Parameter ENTRY_COUNT, default 16: product entries per batch.
REQ-003: Parameter COORD_WIDTH, default 8: width of the row and column coordinates.
REQ-004: clk, input, 1: the single clock; all state is updated on its rising edge.
REQ-005: reset_n, input, 1: asynchronous, active-low reset.
REQ-006: in_valid, input, 1: a batch is presented.
REQ-007: in_ready, output, 1: the scheduler can accept a batch.
REQ-008: in_bitwidth, input, 2: precision mode; 0, 1 or 2 (value 3 is treated as 2).
REQ-009: in_entry_valid, input, ENTRY_COUNT: per-entry valid mask.
REQ-010: in_row[ENTRY_COUNT], in_col[ENTRY_COUNT], input, COORD_WIDTH each: per-entry coordinates.
REQ-011: in_data[ENTRY_COUNT], input, 8 each: per-entry product value.
REQ-012: buf_we[BANK_COUNT], output, 1 each: bank write enable.
REQ-013: buf_row[BANK_COUNT], buf_col[BANK_COUNT], output, COORD_WIDTH each: write coordinates.
REQ-014: buf_data[BANK_COUNT], output, 8 each: write data.
REQ-015: crossbar_stall, output, 1: high while a batch is draining.
REQ-016: batch_done, output, 1: one-cycle pulse when a batch has fully drained.
REQ-017: conflict_cycles, output, 16: saturating count of issue cycles that deferred at least one entry.

Function
REQ-018: The FSM has two states, IDLE and ISSUE; in_ready = (state == IDLE); crossbar_stall = (state == ISSUE).
REQ-019: In IDLE with in_valid = 1 at a rising edge, the block latches the mask into a pending register, latches rows, columns, data and bitwidth, and moves to ISSUE; the inputs are then ignored until IDLE is reached again.
REQ-020: Bank mapping per entry, with b = the latched bitwidth:
- bank = (col + 3*(row >> b) + (row mod 2^b) * (BANK_COUNT >> b)) mod BANK_COUNT;
- all arithmetic is done wide enough that no intermediate truncation occurs before the final modulo.
REQ-021: Each ISSUE cycle, entries are scanned in ascending index. A pending entry is granted if its bank is not already claimed by a lower-index grant in the same cycle. Each granted entry claims its bank.
REQ-022: Each grant is registered at the next edge:
- buf_we[bank] = 1;
- buf_row, buf_col and buf_data take the entry's values;
- the entry's pending bit clears.
REQ-023: Banks with no grant in a cycle register buf_we = 0; their buf_row, buf_col and buf_data hold their previous values.
REQ-024: At the edge where pending becomes zero, the state returns to IDLE and batch_done is registered high for exactly one cycle.
REQ-025: Latency: a batch accepted at edge k with no bank conflicts produces all its writes after edge k+1, with batch_done high after edge k+1 and in_ready high again after edge k+1.
REQ-026: A batch needing N issue cycles holds crossbar_stall high for exactly N cycles.
REQ-027: Empty mask (in_entry_valid = 0): the batch is accepted, there is one ISSUE cycle with no writes, batch_done pulses, and the state returns to IDLE.
REQ-028: conflict_cycles increments at the end of any ISSUE cycle in which at least one pending entry was not granted; it saturates at 0xFFFF and is never cleared except by reset.
REQ-029: Worst case (all entries on one bank) drains in ENTRY_COUNT cycles in index order; no entry is ever dropped or duplicated.
REQ-030: bitwidth is sampled only on acceptance; changes while in ISSUE have no effect on the batch in flight.

Reset
REQ-031: When reset_n is asserted, the outputs take these values immediately, independent of clk:
- state = IDLE, pending = 0;
- all buf_we, buf_row, buf_col and buf_data = 0;
- batch_done = 0, conflict_cycles = 0;
- hence in_ready = 1 and crossbar_stall = 0.
REQ-032: Reset in the middle of a batch discards that batch: no further writes are made and no batch_done pulse is produced.

Verification (BANK_COUNT = 16, ENTRY_COUNT = 16)
REQ-033: b=0, mask=0x0003, entry0 (r0,c5,d=0x11), entry1 (r1,c5,d=0x22) -> one cycle; buf_we[5]=1 with 0x11 and buf_we[8]=1 with 0x22; batch_done pulses; conflict_cycles=0.
REQ-034: b=0, mask=0x0003, both entries (r0,c5) with d=0x11 and d=0x22 -> cycle 1: bank5 written with 0x11; cycle 2: bank5 written with 0x22; stall high for 2 cycles; conflict_cycles=1.
REQ-035: b=2, entry0 (r5,c2) -> bank 9 written (3 + 4 + 2).
REQ-036: b=0, all 16 entries on (r0,c0) with d=index -> 16 consecutive writes to bank0 with data 0..15 in order; conflict_cycles=15.
REQ-037: Mask=0 -> no buf_we asserted; batch_done after 1 cycle. Separately: reset_n low during the second cycle of the REQ-034 batch -> outputs zero immediately, no further write, in_ready=1.
